// File: rtl/fruit_spawn_scheduler.sv
// Fruit launch scheduler: paces spawns on frame ticks, allocates free slots, tracks cut/miss, lives, score, difficulty.
// Optional BONUS_LIFE_EN: one extra life (max 7) each time score crosses a multiple of 50.
module fruit_spawn_scheduler #(
  parameter int         NUM_SLOTS           = 4,
  parameter int         LIVES_INIT          = 3,
  parameter int         SPAWN_INTERVAL_INIT = 60,
  parameter int         SPAWN_INTERVAL_MIN  = 20,
  parameter int         INTERVAL_STEP       = 4,
  parameter int         SCORE_STEP          = 10,
  parameter logic [9:0] LFSR_SEED           = 10'h2A5
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         throw_fruit,
  input  logic                         frame_tick,
  input  logic [NUM_SLOTS-1:0]         slot_cut,
  input  logic [NUM_SLOTS-1:0]         slot_miss,
  input  logic                         launch_ready,
  output logic                         launch_valid,
  output logic [$clog2(NUM_SLOTS)-1:0] launch_slot,
  output logic [9:0]                   launch_x,
  output logic [3:0]                   launch_vel,
  output logic [NUM_SLOTS-1:0]         slot_active,
  output logic [2:0]                   lives,
  output logic [9:0]                   score,
  output logic [7:0]                   interval
);
  localparam int SW = $clog2(NUM_SLOTS);

  typedef enum logic [1:0] {IDLE, COUNT, PICK, ISSUE} state_t;

  typedef struct packed {
    logic [SW-1:0] slot;
    logic [9:0]    x;
    logic [3:0]    vel;
  } launch_t;

  state_t         state, state_nxt;
  launch_t        req;
  logic [9:0]     lfsr;
  logic [7:0]     frame_cnt;
  logic [7:0]     step_cnt;

  logic [NUM_SLOTS-1:0] cut_acc, miss_acc, launch_set;
  logic [3:0]           n_cut, n_miss;
  logic                 any_free;
  logic [SW-1:0]        free_idx;
  logic                 handshake, reload, count_en;
  logic [10:0]          score_sum;
  logic [9:0]           score_nxt;
  logic [2:0]           lives_dec, lives_nxt;
  logic [8:0]           step_sum;
  logic                 step_hit;
  logic [7:0]           interval_dec;

  assign launch_valid = (state == ISSUE);
  assign launch_slot  = req.slot;
  assign launch_x     = req.x;
  assign launch_vel   = req.vel;

  // Cut beats miss on the same slot; pulses on idle slots never count.
  assign cut_acc  = slot_cut & slot_active;
  assign miss_acc = slot_miss & slot_active & ~slot_cut;

  assign handshake  = (state == ISSUE) && launch_ready;
  assign reload     = handshake || ((state == PICK) && !any_free);
  assign count_en   = (state == COUNT) && frame_tick && (lives != 3'd0);
  assign launch_set = handshake ? (NUM_SLOTS'(1) << req.slot) : '0;

  always_comb begin
    n_cut  = '0;
    n_miss = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      n_cut  = n_cut + 4'(cut_acc[i]);
      n_miss = n_miss + 4'(miss_acc[i]);
    end
  end

  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_active[i]) begin
        any_free = 1'b1;
        free_idx = SW'(i);
      end
    end
  end

  assign score_sum = {1'b0, score} + {7'd0, n_cut};
  assign score_nxt = score_sum[10] ? 10'd1023 : score_sum[9:0];
  assign lives_dec = ({1'b0, lives} > n_miss) ? (lives - 3'(n_miss)) : 3'd0;

  always_comb begin
    lives_nxt = lives_dec;
`ifdef BONUS_LIFE_EN
    // Misses are applied first, then the bonus for crossing a multiple of 50.
    if (((score_nxt / 10'd50) != (score / 10'd50)) && (lives_dec != 3'd7))
      lives_nxt = lives_dec + 3'd1;
`endif
  end

  assign step_sum     = {1'b0, step_cnt} + {5'd0, n_cut};
  assign step_hit     = (step_sum >= 9'(SCORE_STEP));
  assign interval_dec = (int'(interval) >= SPAWN_INTERVAL_MIN + INTERVAL_STEP) ?
                        (interval - 8'(INTERVAL_STEP)) : 8'(SPAWN_INTERVAL_MIN);

  always_ff @(posedge Clk) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (throw_fruit) state_nxt = COUNT;
      COUNT:   if (count_en && (frame_cnt == 8'd1)) state_nxt = PICK;
      PICK:    state_nxt = any_free ? ISSUE : COUNT;
      ISSUE:   if (launch_ready) state_nxt = COUNT;
      default: state_nxt = IDLE;
    endcase
    if ((state != IDLE) && !throw_fruit) state_nxt = IDLE;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      req         <= '0;
      slot_active <= '0;
      lives       <= 3'(LIVES_INIT);
      score       <= '0;
      interval    <= 8'(SPAWN_INTERVAL_INIT);
      step_cnt    <= '0;
      frame_cnt   <= '0;
      lfsr        <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
      if (state == IDLE) begin
        if (throw_fruit) begin
          lives       <= 3'(LIVES_INIT);
          score       <= '0;
          interval    <= 8'(SPAWN_INTERVAL_INIT);
          step_cnt    <= '0;  // difficulty progress restarts with the score
          slot_active <= '0;
          frame_cnt   <= 8'(SPAWN_INTERVAL_INIT);
        end
      end else if (!throw_fruit) begin
        // Game stopped: lives and score stay visible for the end screen.
        slot_active <= '0;
      end else begin
        slot_active <= (slot_active & ~cut_acc & ~miss_acc) | launch_set;
        score       <= score_nxt;
        lives       <= lives_nxt;
        step_cnt    <= step_hit ? 8'(step_sum - 9'(SCORE_STEP)) : step_sum[7:0];
        if (step_hit) interval <= interval_dec;
        if (count_en && (frame_cnt != 8'd1)) frame_cnt <= frame_cnt - 8'd1;
        if (reload) frame_cnt <= interval;
        if ((state == PICK) && any_free) begin
          req.slot <= free_idx;
          req.x    <= 10'd40 + {1'b0, lfsr[8:0]};
          req.vel  <= {1'b1, lfsr[2:0]};
        end
      end
    end
  end

endmodule

// File: tb/tb_fruit_spawn_scheduler.sv
// Bench for fruit_spawn_scheduler: behavioural game model checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_fruit_spawn_scheduler;
  localparam int         NS       = 4;
  localparam int         LIVES0   = 3;
  localparam int         INT0     = 60;
  localparam int         INT_MIN  = 20;
  localparam int         INT_STEP = 4;
  localparam int         CUT_STEP = 10;
  localparam logic [9:0] SEED     = 10'h2A5;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          throw_fruit = 1'b0;
  logic          frame_tick = 1'b0;
  logic          launch_ready = 1'b0;
  logic [NS-1:0] slot_cut = '0;
  logic [NS-1:0] slot_miss = '0;
  logic          launch_valid;
  logic [1:0]    launch_slot;
  logic [9:0]    launch_x;
  logic [3:0]    launch_vel;
  logic [NS-1:0] slot_active;
  logic [2:0]    lives;
  logic [9:0]    score;
  logic [7:0]    interval;

  int n_checks = 0;
  int n_fail   = 0;

  fruit_spawn_scheduler #(
    .NUM_SLOTS(NS), .LIVES_INIT(LIVES0), .SPAWN_INTERVAL_INIT(INT0),
    .SPAWN_INTERVAL_MIN(INT_MIN), .INTERVAL_STEP(INT_STEP),
    .SCORE_STEP(CUT_STEP), .LFSR_SEED(SEED)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .throw_fruit(throw_fruit), .frame_tick(frame_tick),
    .slot_cut(slot_cut), .slot_miss(slot_miss), .launch_ready(launch_ready),
    .launch_valid(launch_valid), .launch_slot(launch_slot), .launch_x(launch_x),
    .launch_vel(launch_vel), .slot_active(slot_active), .lives(lives),
    .score(score), .interval(interval)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: game phase 0 idle, 1 waiting for spawn, 2 choosing a slot, 3 offering a launch.
  int            m_phase, m_cnt, m_lives, m_score, m_interval, m_steps, m_slot, m_x, m_vel;
  bit [NS-1:0]   m_active;
  bit [9:0]      m_lfsr;
  bit            m_ok = 1'b0;

  always @(posedge Clk) begin : model
    int ph, cnt, lv, sc, iv, st, sl, x, vel, ncut, nmiss, found;
    bit [NS-1:0] act;
    bit [9:0] lf;
    ph = m_phase; cnt = m_cnt; lv = m_lives; sc = m_score; iv = m_interval;
    st = m_steps; sl = m_slot; x = m_x; vel = m_vel; act = m_active; lf = m_lfsr;
    if (!Reset_n) begin
      ph = 0; cnt = 0; lv = LIVES0; sc = 0; iv = INT0; st = 0;
      sl = 0; x = 0; vel = 0; act = '0; lf = SEED;
    end else begin
      lf = {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
      if (m_phase == 0) begin
        if (throw_fruit) begin
          ph = 1; lv = LIVES0; sc = 0; iv = INT0; st = 0; act = '0; cnt = INT0;
        end
      end else if (!throw_fruit) begin
        ph = 0; act = '0;
      end else begin
        ncut = 0; nmiss = 0;
        for (int i = 0; i < NS; i++) begin
          if (m_active[i] && slot_cut[i]) begin ncut++; act[i] = 1'b0; end
          else if (m_active[i] && slot_miss[i]) begin nmiss++; act[i] = 1'b0; end
        end
        case (m_phase)
          1: if (frame_tick && m_lives > 0) begin
               if (m_cnt == 1) ph = 2;
               else cnt = m_cnt - 1;
             end
          2: begin
               found = -1;
               for (int i = NS - 1; i >= 0; i--) if (!m_active[i]) found = i;
               if (found < 0) begin cnt = m_interval; ph = 1; end
               else begin
                 sl = found; x = 40 + int'(m_lfsr[8:0]); vel = 8 + int'(m_lfsr[2:0]); ph = 3;
               end
             end
          3: if (launch_ready) begin act[m_slot] = 1'b1; cnt = m_interval; ph = 1; end
          default: ;
        endcase
        sc = (m_score + ncut > 1023) ? 1023 : m_score + ncut;
        lv = (m_lives > nmiss) ? m_lives - nmiss : 0;
`ifdef BONUS_LIFE_EN
        if ((sc / 50) != (m_score / 50) && lv < 7) lv = lv + 1;
`endif
        st = m_steps + ncut;
        if (st >= CUT_STEP) begin
          st = st - CUT_STEP;
          iv = (m_interval - INT_STEP < INT_MIN) ? INT_MIN : m_interval - INT_STEP;
        end
      end
    end
    m_phase <= ph; m_cnt <= cnt; m_lives <= lv; m_score <= sc; m_interval <= iv;
    m_steps <= st; m_slot <= sl; m_x <= x; m_vel <= vel; m_active <= act; m_lfsr <= lf;
    if (!Reset_n) m_ok <= 1'b1;
  end

  always @(negedge Clk) begin
    if (m_ok) begin
      chk("launch_valid", int'(launch_valid), (m_phase == 3) ? 1 : 0);
      chk("launch_slot",  int'(launch_slot), m_slot);
      chk("launch_x",     int'(launch_x), m_x);
      chk("launch_vel",   int'(launch_vel), m_vel);
      chk("slot_active",  int'(slot_active), int'(m_active));
      chk("lives",        int'(lives), m_lives);
      chk("score",        int'(score), m_score);
      chk("interval",     int'(interval), m_interval);
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #2;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!launch_valid && n < budget) begin cyc(); n++; end
    chk("launch_valid_wait", int'(launch_valid), 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, pinned56;
    Reset_n = 1'b0;
    repeat (3) cyc();
    chk("rst_valid", int'(launch_valid), 0);
    chk("rst_active", int'(slot_active), 0);
    chk("rst_lives", int'(lives), 3);
    chk("rst_score", int'(score), 0);
    chk("rst_interval", int'(interval), 60);

    // Fill all four slots, lowest free first.
    Reset_n = 1'b1; throw_fruit = 1'b1; launch_ready = 1'b1; frame_tick = 1'b1;
    for (int k = 0; k < NS; k++) begin
      wait_valid(200);
      chk("fill_slot", int'(launch_slot), k);
      chk("fill_x_range", int'(launch_x >= 10'd40 && launch_x <= 10'd551), 1);
      chk("fill_vel_range", int'(launch_vel >= 4'd8), 1);
      cyc();
      chk("fill_active", int'(slot_active), (1 << (k + 1)) - 1);
    end
    seen = 0;
    repeat (150) begin cyc(); seen |= int'(launch_valid); end
    chk("no_fifth_launch", seen, 0);

    // Cut/miss mix; slot 3 is made idle first so its pulses are ignored.
    frame_tick = 1'b0;
    slot_cut = 4'b1000; cyc(); slot_cut = '0;
    chk("cut3_score", int'(score), 1);
    chk("cut3_active", int'(slot_active), 4'b0111);
    slot_cut = 4'b1011; slot_miss = 4'b1101; cyc(); slot_cut = '0; slot_miss = '0;
    chk("mix_score", int'(score), 3);
    chk("mix_lives", int'(lives), 2);
    chk("mix_active", int'(slot_active), 0);

    // Backpressure: request must hold while ready is low.
    frame_tick = 1'b1; launch_ready = 1'b0;
    wait_valid(200);
    repeat (20) cyc();
    chk("hold_valid", int'(launch_valid), 1);
    chk("hold_slot", int'(launch_slot), 0);
    launch_ready = 1'b1; cyc();
    chk("hold_done_active", int'(slot_active), 1);
    chk("hold_done_valid", int'(launch_valid), 0);

    // Difficulty ramp: cut everything in flight until score passes 110.
    pinned56 = 0;
    for (int n = 0; n < 20000 && score < 10'd110; n++) begin
      slot_cut = ($urandom_range(0, 1) == 1) ? slot_active : '0;
      cyc();
      if (!pinned56 && score >= 10'd10 && score <= 10'd19) begin
        chk("interval_first_step", int'(interval), 56);
        pinned56 = 1;
      end
    end
    slot_cut = '0;
    chk("ramp_score_reached", int'(score >= 10'd110), 1);
    chk("interval_floor", int'(interval), 20);

    // Stop the game: slots clear, score is held.
    throw_fruit = 1'b0; cyc();
    chk("stop_active", int'(slot_active), 0);
    chk("stop_score_held", int'(score >= 10'd110), 1);
    repeat (5) cyc();

    // New game: lose all lives.
    throw_fruit = 1'b1; cyc();
    chk("new_lives", int'(lives), 3);
    chk("new_score", int'(score), 0);
    chk("new_interval", int'(interval), 60);
    for (int k = 0; k < NS; k++) begin wait_valid(200); cyc(); end
    frame_tick = 1'b0;
    for (int k = 0; k < NS; k++) begin
      slot_miss = 4'(1 << k); cyc(); slot_miss = '0;
      chk("miss_lives", int'(lives), (k < 3) ? 2 - k : 0);
    end
    chk("miss_active", int'(slot_active), 0);
    frame_tick = 1'b1; seen = 0;
    repeat (150) begin cyc(); seen |= int'(launch_valid); end
    chk("dead_no_launch", seen, 0);

    // Randomized play, including stray pulses, dropouts and resets.
    throw_fruit = 1'b0; cyc();
    for (int n = 0; n < 4000; n++) begin
      Reset_n      = ($urandom_range(0, 499) != 0);
      throw_fruit  = ($urandom_range(0, 399) != 0);
      frame_tick   = ($urandom_range(0, 3) != 0);
      launch_ready = ($urandom_range(0, 1) == 1);
      slot_cut     = 4'($urandom & $urandom & $urandom);
      slot_miss    = 4'($urandom & $urandom & $urandom & $urandom);
      cyc();
    end

    // Reset while a launch is being offered.
    Reset_n = 1'b1; throw_fruit = 1'b0; slot_cut = '0; slot_miss = '0; cyc();
    throw_fruit = 1'b1; frame_tick = 1'b1; launch_ready = 1'b1;
    wait_valid(200); cyc();
    launch_ready = 1'b0;
    wait_valid(200);
    Reset_n = 1'b0; cyc();
    chk("midissue_valid", int'(launch_valid), 0);
    chk("midissue_active", int'(slot_active), 0);
    chk("midissue_lives", int'(lives), 3);
    chk("midissue_score", int'(score), 0);
    chk("midissue_interval", int'(interval), 60);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
